nonblocking_crossbar: RTL

Parametrised N×M packet crossbar with simultaneous connections, header-based routing, per-output round-robin arbitration and a registered output stage. It generalises the statically configured single-path crossbar used in the packet routing interconnect. It needs no control port: each input message routes itself from its destination field, and every output can be busy at once. It sits between the input ports of the interconnect and the downstream routers and consumers.

---
 rtl/nonblocking_crossbar_pkg.sv | 18 +
 rtl/nonblocking_crossbar_if.sv | 27 ++
 rtl/crossbar_rr_arbiter.sv | 43 ++++
 rtl/nonblocking_crossbar.sv | 113 +++++++++++
 4 files changed

// File: rtl/nonblocking_crossbar_pkg.sv
// Shared constants and helpers for the nonblocking crossbar: dest-field decode and counter width.
package nonblocking_crossbar_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int MSG_W_MAX  = 512;

  function automatic int dest_width(input int n_outputs);
    return $clog2(n_outputs);
  endfunction

  // Destination lives in the top dest_w bits of the message.
  function automatic int unsigned dest_field(input logic [MSG_W_MAX-1:0] msg,
                                             input int unsigned bit_width,
                                             input int unsigned dest_w);
    return 32'(msg >> (bit_width - dest_w)) & ((32'd1 << dest_w) - 32'd1);
  endfunction

endpackage

// File: rtl/nonblocking_crossbar_if.sv
// Crossbar input/output channel bundle; slave = crossbar side, master = traffic source/sink side.
interface nonblocking_crossbar_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_INPUTS  = 4,
  parameter int N_OUTPUTS = 4
);
  import nonblocking_crossbar_pkg::*;

  logic [N_INPUTS-1:0][BIT_WIDTH-1:0]  recv_msg;
  logic [N_INPUTS-1:0]                 recv_val;
  logic [N_INPUTS-1:0]                 recv_rdy;
  logic [N_OUTPUTS-1:0][BIT_WIDTH-1:0] send_msg;
  logic [N_OUTPUTS-1:0]                send_val;
  logic [N_OUTPUTS-1:0]                send_rdy;
  logic [DROP_CNT_W-1:0]               drop_count;

  modport master (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val, drop_count
  );

  modport slave (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val, drop_count
  );

endinterface

// File: rtl/crossbar_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, combinational.
// ptr moves past the granted input only when advance confirms a transfer.
module crossbar_rr_arbiter #(
  parameter int N_INPUTS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] req,
  output logic [N_INPUTS-1:0] grant,
  input  logic                advance
);

  localparam int PTR_W = $clog2(N_INPUTS);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] next_ptr;
  logic             found;
  int               idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_INPUTS; k++) begin
      idx = (int'(ptr) + k) % N_INPUTS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        next_ptr   = PTR_W'((idx + 1) % N_INPUTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/nonblocking_crossbar.sv
// N x M self-routing crossbar, per-output round-robin, 1-entry output register (1-cycle latency).
// A full output holds its data until send_rdy; inputs aimed at it stall while others proceed.
module nonblocking_crossbar
  import nonblocking_crossbar_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_INPUTS  = 4,
  parameter int N_OUTPUTS = 4
) (
  input logic                   clk,
  input logic                   reset,
  nonblocking_crossbar_if.slave bus
);

  localparam int DEST_W = dest_width(N_OUTPUTS);

  logic [N_INPUTS-1:0][DEST_W-1:0]     dest;
  logic [N_INPUTS-1:0]                 oor;
  logic [N_INPUTS-1:0]                 rdy;
  logic [N_OUTPUTS-1:0][N_INPUTS-1:0]  req;
  logic [N_OUTPUTS-1:0][N_INPUTS-1:0]  grant;
  logic [N_OUTPUTS-1:0]                can_accept;
  logic [N_OUTPUTS-1:0]                accept;
  logic [N_OUTPUTS-1:0][BIT_WIDTH-1:0] win_msg;
  logic [N_OUTPUTS-1:0]                full;
  logic [N_OUTPUTS-1:0][BIT_WIDTH-1:0] data;
  logic [DROP_CNT_W-1:0]               drop_cnt;
  logic [DROP_CNT_W-1:0]               drop_next;

  always_comb begin
    dest = '0;
    oor  = '0;
    req  = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      dest[i] = DEST_W'(dest_field(MSG_W_MAX'(bus.recv_msg[i]), BIT_WIDTH, DEST_W));
      oor[i]  = int'(dest[i]) >= N_OUTPUTS;
      for (int o = 0; o < N_OUTPUTS; o++) begin
        req[o][i] = bus.recv_val[i] && (dest[i] == DEST_W'(o));
      end
    end
  end

  for (genvar o = 0; o < N_OUTPUTS; o++) begin : g_arb
    crossbar_rr_arbiter #(.N_INPUTS(N_INPUTS)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req[o]),
      .grant   (grant[o]),
      .advance (accept[o])
    );
  end

  // An output can take a new message when empty or draining this cycle.
  always_comb begin
    can_accept = '0;
    accept     = '0;
    win_msg    = '0;
    for (int o = 0; o < N_OUTPUTS; o++) begin
      can_accept[o] = !full[o] || bus.send_rdy[o];
      accept[o]     = !reset && can_accept[o] && (|grant[o]);
      for (int i = 0; i < N_INPUTS; i++) begin
        if (grant[o][i]) begin
          win_msg[o] = bus.recv_msg[i];
        end
      end
    end
  end

  // Out-of-range messages are always accepted so they can be discarded.
  always_comb begin
    rdy = oor;
    for (int i = 0; i < N_INPUTS; i++) begin
      for (int o = 0; o < N_OUTPUTS; o++) begin
        if (grant[o][i] && can_accept[o]) begin
          rdy[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    drop_next = drop_cnt;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (oor[i] && bus.recv_val[i] && (drop_next != '1)) begin
        drop_next = drop_next + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full     <= '0;
      data     <= '0;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_next;
      for (int o = 0; o < N_OUTPUTS; o++) begin
        if (accept[o]) begin
          full[o] <= 1'b1;
          data[o] <= win_msg[o];
        end else if (bus.send_rdy[o]) begin
          full[o] <= 1'b0;
        end
      end
    end
  end

  assign bus.recv_rdy   = reset ? '0 : rdy;
  assign bus.send_val   = full;
  assign bus.send_msg   = data;
  assign bus.drop_count = drop_cnt;

endmodule
